// File: rtl/stream_token_if.sv
// stream_token_if
// Valid/ready carrier for the sparse token stream (17-bit tokens by default,
// top bit = control flag).
//   data_in        token driven by the producer
//   data_in_valid  producer has a token on data_in
//   data_in_ready  consumer can take the token this cycle
// Modports: master = producer side, slave = consumer side.
interface stream_token_if #(
  parameter int unsigned DATA_WIDTH = 17
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/stream_token_sink.sv
// stream_token_sink
// Receiving end of one sparse token stream. Accepts tokens over a valid/ready
// handshake, classifies each as data / stop / done / malformed, keeps per-tile
// counters and a 16-bit checksum, and raises done once TX_NUM done tokens have
// been accepted.
//
// Optional feature macro: STREAM_TOKEN_SINK_STALL_EN
//   defined   : ready in RECV is withheld when lfsr[3:0] < STALL_THRESH, using a
//               16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) seeded with LFSR_SEED.
//   undefined : no LFSR; ready in RECV simply follows clk_en.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   clk_en         0 freezes all state and forces ready low
//   flush          synchronous clear back to IDLE, highest priority
//   tile_en        starts a tile (IDLE -> RECV); ignored once receiving
//   in_if          token stream, slave side (data_in, data_in_valid, data_in_ready)
//   done           TX_NUM done tokens received
//   data_count     accepted data tokens
//   stop_count     accepted stop tokens
//   cycle_count    clk_en cycles spent in RECV
//   checksum       sum mod 2^16 of data_in[15:0] over data tokens
//   last_stop_lvl  level field of the most recent stop token
//   err            sticky: a malformed control token was seen
module stream_token_sink #(
  parameter int unsigned DATA_WIDTH   = 17,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned TX_NUM       = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned STALL_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 flush,
  input  logic                 tile_en,
  stream_token_if.slave        in_if,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] data_count,
  output logic [CNT_WIDTH-1:0] stop_count,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [15:0]          checksum,
  output logic [7:0]           last_stop_lvl,
  output logic                 err
);

  localparam int unsigned CTRL_BIT = DATA_WIDTH - 1;
  // Wide enough to hold TX_NUM itself so the final increment never wraps.
  localparam int unsigned TXW      = $clog2(TX_NUM + 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_NUM - 1);

  // Reject parameter sets the datapath cannot honour.
  if (TX_NUM == 0 || STALL_THRESH > 16 || LFSR_SEED == 16'h0000 || DATA_WIDTH < 17) begin : g_cfg_check
    $error("stream_token_sink: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [DATA_WIDTH-1:0] tok_s;
  logic                  is_data_s;
  logic                  is_stop_s;
  logic                  is_done_s;
  logic                  is_bad_s;
  logic                  ready_s;
  logic                  stall_ok_s;
  logic                  accept_s;
  logic                  last_done_s;

  logic [TXW-1:0]        tx_cnt_r;
  logic                  done_r;
  logic                  err_r;
  logic [CNT_WIDTH-1:0]  data_count_r;
  logic [CNT_WIDTH-1:0]  stop_count_r;
  logic [CNT_WIDTH-1:0]  cycle_count_r;
  logic [15:0]           checksum_r;
  logic [7:0]            last_stop_lvl_r;

  // Running checksum step; wraps modulo 2^16 by construction.
  function automatic logic [15:0] checksum_add(input logic [15:0] acc, input logic [15:0] val);
    return acc + val;
  endfunction

  assign tok_s       = in_if.data_in;
  assign accept_s    = in_if.data_in_valid & ready_s;
  assign last_done_s = (tx_cnt_r == TX_LAST);

`ifdef STREAM_TOKEN_SINK_STALL_EN
  localparam logic [4:0] STALL_THRESH_C = 5'(STALL_THRESH);

  logic [15:0] lfsr_r;

  // One Fibonacci step of x^16+x^14+x^13+x^11 in right-shift form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
    return {fb, cur[15:1]};
  endfunction

  // Stall LFSR: free-runs on every enabled RECV cycle, independent of traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (flush) begin
      lfsr_r <= LFSR_SEED;
    end else if (clk_en && (state_r == ST_RECV)) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // A threshold of 16 can never be met by a 4-bit value, so compare at 5 bits.
  assign stall_ok_s = ({1'b0, lfsr_r[3:0]} >= STALL_THRESH_C);
`else
  assign stall_ok_s = 1'b1;
`endif

  // Token classification; bit 9 set on a control token marks it malformed
  // regardless of bit 8.
  always_comb begin
    is_data_s = 1'b0;
    is_stop_s = 1'b0;
    is_done_s = 1'b0;
    is_bad_s  = 1'b0;
    if (!tok_s[CTRL_BIT]) begin
      is_data_s = 1'b1;
    end else if (tok_s[9]) begin
      is_bad_s = 1'b1;
    end else if (tok_s[8]) begin
      is_done_s = 1'b1;
    end else begin
      is_stop_s = 1'b1;
    end
  end

  // FSM state register; flush acts as a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; any accept already implies clk_en through ready.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clk_en && tile_en) begin
          next_state_s = ST_RECV;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (accept_s && is_done_s && last_done_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RECV;
        end
      end
      ST_DONE: begin
        next_state_s = ST_DONE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: ready depends only on state, LFSR and clk_en.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s = 1'b0;
      ST_RECV: ready_s = clk_en & stall_ok_s;
      ST_DONE: ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // Per-tile counters, checksum and flags; each accepted token updates one class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_r        <= '0;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
      data_count_r    <= '0;
      stop_count_r    <= '0;
      cycle_count_r   <= '0;
      checksum_r      <= 16'h0000;
      last_stop_lvl_r <= 8'h00;
    end else if (flush) begin
      tx_cnt_r        <= '0;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
      data_count_r    <= '0;
      stop_count_r    <= '0;
      cycle_count_r   <= '0;
      checksum_r      <= 16'h0000;
      last_stop_lvl_r <= 8'h00;
    end else begin
      if (clk_en && (state_r == ST_RECV)) begin
        cycle_count_r <= cycle_count_r + CNT_WIDTH'(1'b1);
      end
      if (accept_s) begin
        if (is_data_s) begin
          data_count_r <= data_count_r + CNT_WIDTH'(1'b1);
          checksum_r   <= checksum_add(checksum_r, tok_s[15:0]);
        end else if (is_stop_s) begin
          stop_count_r    <= stop_count_r + CNT_WIDTH'(1'b1);
          last_stop_lvl_r <= tok_s[7:0];
        end else if (is_done_s) begin
          tx_cnt_r <= tx_cnt_r + TXW'(1'b1);
          if (last_done_s) begin
            done_r <= 1'b1;
          end
        end else if (is_bad_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign in_if.data_in_ready = ready_s;
  assign done                = done_r;
  assign err                 = err_r;
  assign data_count          = data_count_r;
  assign stop_count          = stop_count_r;
  assign cycle_count         = cycle_count_r;
  assign checksum            = checksum_r;
  assign last_stop_lvl       = last_stop_lvl_r;

endmodule
